// File: rtl/pid_pkg.sv
// Shared widths, limits and signed types for the incremental PID controller.
package pid_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned GAIN_W = 4;
  localparam int unsigned OUT_W  = 15;
  localparam int unsigned ERR_W  = DATA_W + 1;
  localparam int unsigned ACC_W  = OUT_W + 4;

  localparam int OUT_MAX = (2 ** (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W - 1));

  typedef logic signed [ERR_W-1:0] err_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] out_t;

endpackage

// File: rtl/pid_sat.sv
// Combinational signed saturator: clamps an IN_W-bit value into the O_W-bit signed range.
module pid_sat #(
  parameter int unsigned IN_W = 19,
  parameter int unsigned O_W  = 15
) (
  input  logic signed [IN_W-1:0] sum_i,
  output logic signed [O_W-1:0]  sat_o
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-O_W+1){1'b0}}, {(O_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-O_W+1){1'b1}}, {(O_W-1){1'b0}}};

  always_comb begin
    sat_o = sum_i[O_W-1:0];
    if (sum_i > MAX_V) begin
      sat_o = MAX_V[O_W-1:0];
    end else if (sum_i < MIN_V) begin
      sat_o = MIN_V[O_W-1:0];
    end
  end

endmodule

// File: rtl/pid_controller.sv
// Velocity-form PID: u(k) = sat(u(k-1) + kp*(e0-e1) + ki*e0 + kd*(e0-2e1+e2)).
module pid_controller
  import pid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] target,
  input  logic signed [DATA_W-1:0] y,
  input  logic        [GAIN_W-1:0] kp,
  input  logic        [GAIN_W-1:0] ki,
  input  logic        [GAIN_W-1:0] kd,
  output logic signed [OUT_W-1:0]  uk0
);

  err_t e1_q, e1_d;
  err_t e2_q, e2_d;
  out_t uk0_q, uk0_d;

  err_t e0;
  acc_t e0_x, e1_x, e2_x;
  acc_t kp_x, ki_x, kd_x;
  acc_t d_p, d_d, du, sum;

  // All arithmetic runs in the accumulator width, wide enough that nothing wraps
  always_comb begin
    e0   = ERR_W'(target) - ERR_W'(y);
    e0_x = ACC_W'(e0);
    e1_x = ACC_W'(e1_q);
    e2_x = ACC_W'(e2_q);
    kp_x = ACC_W'({1'b0, kp});
    ki_x = ACC_W'({1'b0, ki});
    kd_x = ACC_W'({1'b0, kd});
    d_p  = e0_x - e1_x;
    d_d  = e0_x - e1_x - e1_x + e2_x;
    du   = (kp_x * d_p) + (ki_x * e0_x) + (kd_x * d_d);
    sum  = ACC_W'(uk0_q) + du;
  end

  pid_sat #(
    .IN_W (ACC_W),
    .O_W  (OUT_W)
  ) u_sat (
    .sum_i (sum),
    .sat_o (uk0_d)
  );

  always_comb begin
    e1_d = e0;
    e2_d = e1_q;
  end

  // Saturated output is fed back so the accumulator never winds up
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      uk0_q <= '0;
      e1_q  <= '0;
      e2_q  <= '0;
    end else begin
      uk0_q <= uk0_d;
      e1_q  <= e1_d;
      e2_q  <= e2_d;
    end
  end

  assign uk0 = uk0_q;

endmodule

// File: tb/tb_pid_controller.sv
// Directed and randomized checks of pid_controller against an integer reference model.
module tb_pid_controller;
  import pid_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic signed [DATA_W-1:0] target;
  logic signed [DATA_W-1:0] y;
  logic        [GAIN_W-1:0] kp, ki, kd;
  logic signed [OUT_W-1:0]  uk0;

  int n_chk  = 0;
  int n_pass = 0;
  int m_u    = 0;
  int m_e1   = 0;
  int m_e2   = 0;

  pid_controller dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .target (target),
    .y      (y),
    .kp     (kp),
    .ki     (ki),
    .kd     (kd),
    .uk0    (uk0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int exp);
    n_chk++;
    assert (uk0 === OUT_W'(exp)) n_pass++;
    else $error("FAIL %s: uk0=%0d expected=%0d", tag, uk0, exp);
  endtask

  // Reference: one sample of the velocity-form law with clamping, in plain integers
  task automatic model_edge();
    int e0, du, s;
    e0 = int'(target) - int'(y);
    du = int'(kp) * (e0 - m_e1) + int'(ki) * e0 + int'(kd) * (e0 - 2 * m_e1 + m_e2);
    s  = m_u + du;
    if (s > OUT_MAX) s = OUT_MAX;
    if (s < OUT_MIN) s = OUT_MIN;
    m_e2 = m_e1;
    m_e1 = e0;
    m_u  = s;
  endtask

  task automatic step_exp(input string tag, input int exp);
    @(posedge clk);
    model_edge();
    #1 check(tag, exp);
  endtask

  task automatic step_model(input string tag);
    @(posedge clk);
    model_edge();
    #1 check(tag, m_u);
  endtask

  // Pulse reset between edges and confirm the output clears without a clock
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b1;
    #1 check(tag, 0);
    m_u = 0; m_e1 = 0; m_e2 = 0;
    #1 rst_n = 1'b0;
  endtask

  task automatic set_gains(input int p, input int i, input int d);
    kp = GAIN_W'(p); ki = GAIN_W'(i); kd = GAIN_W'(d);
  endtask

  initial begin
    rst_n  = 1'b1;
    target = 10'sd350;
    y      = '0;
    set_gains(10, 9, 8);
    #1 check("reset_async", 0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", 0);
    @(negedge clk) rst_n = 1'b0;

    step_exp("step_1", 9450);
    step_exp("step_2", 9800);
    step_exp("step_3", 12950);
    step_exp("step_4", 16100);
    step_exp("step_5_sat", 16383);
    step_exp("step_6_hold", 16383);
    step_exp("step_7_hold", 16383);

    y = 10'sd351;
    set_gains(0, 1, 0);
    step_exp("windup_1", 16382);
    step_exp("windup_2", 16381);
    step_exp("windup_3", 16380);

    reset_pulse("reset_pre_neg");
    target = '0;
    y      = 10'sd350;
    set_gains(10, 9, 8);
    step_exp("neg_1", -9450);
    step_exp("neg_2", -9800);
    step_exp("neg_3", -12950);
    step_exp("neg_4", -16100);
    step_exp("neg_5_sat", -16384);
    step_exp("neg_6_hold", -16384);

    reset_pulse("reset_pre_zero");
    target = 10'sd123;
    y      = 10'sd123;
    for (int i = 0; i < 3; i++) step_exp("zero_err", 0);

    reset_pulse("reset_pre_gz");
    target = 10'sd350;
    y      = '0;
    step_exp("gz_1", 9450);
    step_exp("gz_2", 9800);
    set_gains(0, 0, 0);
    for (int i = 0; i < 3; i++) step_exp("gz_hold", 9800);

    reset_pulse("reset_pre_mid");
    set_gains(10, 9, 8);
    step_exp("mid_1", 9450);
    step_exp("mid_2", 9800);
    step_exp("mid_3", 12950);
    reset_pulse("reset_mid_run");
    step_exp("mid_after", 9450);

    for (int i = 0; i < 400; i++) begin
      target = DATA_W'($urandom);
      y      = DATA_W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        y = target - DATA_W'($urandom_range(0, 6));
      end
      set_gains($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) reset_pulse("rand_reset");
      step_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pid_controller.md
Name: pid_controller

Overview:
- Discrete-time incremental (velocity-form) PID controller for the SoC PID block.
- Each clock it samples a signed setpoint and a signed measured plant output, and updates an error history.
- It accumulates a saturated signed control output: u(k) = u(k-1) + Δu(k).
- Runtime-programmable unsigned gains kp, ki, kd. Sits between the sensor/ADC front end and the actuator (PWM) driver.

Parameters:
- DATA_W, 10, width of signed target and y.
- GAIN_W, 4, width of unsigned gains kp/ki/kd.
- OUT_W, 15, width of signed output uk0.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous reset, active-high (asserted = 1 despite the _n name, which matches the codebase's port naming).
- target  in  DATA_W  signed setpoint.
- y  in  DATA_W  signed measured output.
- kp  in  GAIN_W  unsigned proportional gain.
- ki  in  GAIN_W  unsigned integral gain.
- kd  in  GAIN_W  unsigned derivative gain.
- uk0  out  OUT_W  signed control output, registered.

Behaviour:
- Reset (rst_n=1, asynchronous, any time including mid-operation):
  - uk0=0, e1=0, e2=0 immediately.
  - Held while asserted; normal operation resumes at the first rising edge after deassertion.
- Combinational per cycle:
  - e0 = target - y, sign-extended to DATA_W+1 (11 bits); exact, no overflow.
  - dP = e0 - e1 (12 bits).
  - dD = e0 - 2*e1 + e2 (13 bits).
  - Gains are zero-extended to signed GAIN_W+1.
  - Δu = kp*dP + ki*e0 + kd*dD, computed at full precision (≥19-bit signed accumulator).
  - sum = uk0 + Δu at full precision.
- Each rising edge, reset deasserted:
  - uk0 <= sat(sum).
  - e2 <= e1.
  - e1 <= e0.
- sat():
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-16384, 16383].
  - No wrap-around ever.
  - The saturated value (not the unsaturated sum) is the state fed back next cycle (anti-windup).
- Latency: inputs sampled at edge k appear in uk0 immediately after edge k (one register stage).
- Inputs are used combinationally; caller must hold them stable around the edge.
- Gain changes take effect on the next edge; no internal gain registers.
- Gains all zero: uk0 holds its value.
- Zero error with e1 = e2 = 0: uk0 holds its value.
- No handshake, no valid/enable; the controller updates every cycle.

Decomposition:
- Shared package pid_pkg:
  - Constants DATA_W, GAIN_W, OUT_W.
  - Derived ERR_W = DATA_W+1 and ACC_W = OUT_W+4.
  - Local params OUT_MAX = 16383, OUT_MIN = -16384.
  - Typedefs for the error, accumulator and output signed types.
- One sub-module, pid_sat:
  - Parameterised signed saturator, ACC_W in → OUT_W out, purely combinational.
- Error history registers, delta computation and output register stay in pid_controller.

Test Plan:
1. Step response: reset; target=350, y=0, kp=10, ki=9, kd=8 held → uk0 after edges 1..5 = 9450, 9800, 12950, 16100, 16383; remains 16383 thereafter.
2. Negative step: target=0, y=350, same gains → uk0 = -9450, -9800, -12950, -16100, -16384, then holds -16384.
3. Zero error: target=y=123 from reset, gains 10/9/8 → uk0 stays 0 every cycle.
4. Gains zero: run scenario 1 for 2 edges (uk0=9800), then set kp=ki=kd=0 → uk0 holds 9800.
5. Async reset mid-run: during scenario 1 after uk0=12950, pulse rst_n=1 between edges → uk0 goes to 0 without a clock edge. After release, the next edge yields 9450 (history also cleared).
6. Anti-windup recovery: saturate at 16383 via scenario 1, then set y=351, kp=0, ki=1, kd=0 → uk0 decrements by exactly 1 per edge (16382, 16381, ...), with no windup delay.
